uart_rx_param: RTL

//  Parametrised UART receiver for the uart_part subsystem: oversampled serial input, configurable

---
 rtl/uart_rx_param.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with configurable frame format,
// 3-sample majority vote per bit, false-start rejection and per-frame
// parity / framing / break status. rx_i is synchronised internally; all frame
// state advances only on clken_i ticks from the shared baud generator.
module uart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk_50m_i,
   input  logic                 rst_i,
   input  logic                 clken_i,
   input  logic                 rx_i,
   output logic [DATA_BITS-1:0] dout_o,
   output logic                 dout_valid_o,
   output logic                 parity_err_o,
   output logic                 frame_err_o,
   output logic                 break_o,
   output logic                 busy_o
);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [SW-1:0] MID_M1 = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] MID    = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] MID_P1 = SW'(OVERSAMPLE / 2 + 1);
   localparam logic [SW-1:0] LAST   = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] DLAST  = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] SLAST  = BW'(STOP_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t               state_q, state_d;
   logic [1:0]           sync_q;
   logic [SW-1:0]        scnt_q, scnt_d;
   logic [BW-1:0]        bcnt_q, bcnt_d;
   logic [DATA_BITS-1:0] data_q, data_d, data_store;
   logic                 samp_a_q, samp_a_d, samp_b_q, samp_b_d;
   logic                 par_q, par_d;
   logic                 ferr_q, ferr_d;
   logic                 stop_one_q, stop_one_d;
   logic                 wait_high_q, wait_high_d;
   logic                 done_q, done_d;
   logic [DATA_BITS-1:0] dout_q;
   logic                 valid_q, perr_out_q, ferr_out_q, brk_q;
   logic                 rx_s, vote, par_calc, perr_calc, brk_calc;

   assign rx_s = sync_q[1];
   // Samples at MID-1 and MID are held; the MID+1 sample is the live rx_s.
   assign vote = (samp_a_q & samp_b_q) | (samp_a_q & rx_s) | (samp_b_q & rx_s);

   // Data word with the current vote written into bit position bcnt.
   for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_store
      assign data_store[gi] = (bcnt_q == BW'(gi)) ? vote : data_q[gi];
   end

   assign par_calc  = (^data_q) ^ par_q;
   assign perr_calc = (PARITY == 1) ? ~par_calc : (PARITY == 2) ? par_calc : 1'b0;
   assign brk_calc  = (data_q == '0) && ((PARITY == 0) || !par_q) && !stop_one_q;

   // Two-flop synchroniser on the asynchronous serial input, idles high.
   always_ff @(posedge clk_50m_i) begin
      if (rst_i) sync_q <= 2'b11;
      else       sync_q <= {sync_q[0], rx_i};
   end

   // State, counters and datapath registers; result latched one cycle after the frame ends.
   always_ff @(posedge clk_50m_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         scnt_q      <= '0;
         bcnt_q      <= '0;
         data_q      <= '0;
         samp_a_q    <= 1'b1;
         samp_b_q    <= 1'b1;
         par_q       <= 1'b0;
         ferr_q      <= 1'b0;
         stop_one_q  <= 1'b0;
         wait_high_q <= 1'b0;
         done_q      <= 1'b0;
         dout_q      <= '0;
         valid_q     <= 1'b0;
         perr_out_q  <= 1'b0;
         ferr_out_q  <= 1'b0;
         brk_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         scnt_q      <= scnt_d;
         bcnt_q      <= bcnt_d;
         data_q      <= data_d;
         samp_a_q    <= samp_a_d;
         samp_b_q    <= samp_b_d;
         par_q       <= par_d;
         ferr_q      <= ferr_d;
         stop_one_q  <= stop_one_d;
         wait_high_q <= wait_high_d;
         done_q      <= done_d;
         valid_q     <= done_q;
         if (done_q) begin
            dout_q     <= data_q;
            perr_out_q <= perr_calc;
            ferr_out_q <= ferr_q;
            brk_q      <= brk_calc;
         end
      end
   end

   // Next-state and datapath update, evaluated only on oversample ticks.
   always_comb begin
      state_d     = state_q;
      scnt_d      = scnt_q;
      bcnt_d      = bcnt_q;
      data_d      = data_q;
      samp_a_d    = samp_a_q;
      samp_b_d    = samp_b_q;
      par_d       = par_q;
      ferr_d      = ferr_q;
      stop_one_d  = stop_one_q;
      wait_high_d = wait_high_q;
      done_d      = 1'b0;
      if (clken_i) begin
         if (scnt_q == MID_M1) samp_a_d = rx_s;
         if (scnt_q == MID)    samp_b_d = rx_s;
         case (state_q)
            S_IDLE: begin
               scnt_d = '0;
               bcnt_d = '0;
               if (wait_high_q) begin
                  if (rx_s) wait_high_d = 1'b0;
               end else if (!rx_s) begin
                  state_d = S_START;
               end
            end
            S_START: begin
               scnt_d = scnt_q + 1'b1;
               if (scnt_q == MID_P1 && vote) begin
                  state_d = S_IDLE;
                  scnt_d  = '0;
               end else if (scnt_q == LAST) begin
                  state_d    = S_DATA;
                  scnt_d     = '0;
                  bcnt_d     = '0;
                  par_d      = 1'b0;
                  ferr_d     = 1'b0;
                  stop_one_d = 1'b0;
               end
            end
            S_DATA: begin
               scnt_d = scnt_q + 1'b1;
               if (scnt_q == MID_P1) data_d = data_store;
               if (scnt_q == LAST) begin
                  scnt_d = '0;
                  if (bcnt_q == DLAST) begin
                     bcnt_d  = '0;
                     state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                  end else begin
                     bcnt_d = bcnt_q + 1'b1;
                  end
               end
            end
            S_PARITY: begin
               scnt_d = scnt_q + 1'b1;
               if (scnt_q == MID_P1) par_d = vote;
               if (scnt_q == LAST) begin
                  scnt_d  = '0;
                  bcnt_d  = '0;
                  state_d = S_STOP;
               end
            end
            S_STOP: begin
               scnt_d = scnt_q + 1'b1;
               if (scnt_q == MID_P1) begin
                  if (vote) stop_one_d = 1'b1;
                  else      ferr_d     = 1'b1;
                  // Last stop bit ends the frame half a bit early for baud tolerance.
                  if (bcnt_q == SLAST) begin
                     state_d     = S_IDLE;
                     scnt_d      = '0;
                     bcnt_d      = '0;
                     done_d      = 1'b1;
                     wait_high_d = ferr_q | ~vote;
                  end
               end else if (scnt_q == LAST) begin
                  scnt_d = '0;
                  bcnt_d = bcnt_q + 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Output decode.
   always_comb begin
      busy_o       = (state_q != S_IDLE);
      dout_o       = dout_q;
      dout_valid_o = valid_q;
      parity_err_o = perr_out_q;
      frame_err_o  = ferr_out_q;
      break_o      = brk_q;
   end
endmodule
